// File: rtl/dpm_pkg.sv
// Shared definitions for the DPM condition-code logic: CC control
// encodings, data-size codes, the CC-flag bundle and the FSM states.
package dpm_pkg;

  localparam logic [2:0] CC_HOLD  = 3'b000;
  localparam logic [2:0] CC_UCC   = 3'b001;
  localparam logic [2:0] CC_ALL   = 3'b010;
  localparam logic [2:0] CC_MOVE  = 3'b011;
  localparam logic [2:0] CC_WLOAD = 3'b100;
  localparam logic [2:0] CC_CLRVC = 3'b101;

  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_WORD = 2'b01;
  localparam logic [1:0] DSIZE_LONG = 2'b10;
  localparam logic [1:0] DSIZE_QUAD = 2'b11;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } cc_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_DBL_HI = 1'b1
  } state_t;

  // True for the encodings that load the micro-flags from the ALU result.
  function automatic logic is_flag_load(input logic [2:0] ctl);
    return (ctl == CC_UCC) || (ctl == CC_ALL) || (ctl == CC_MOVE);
  endfunction

endpackage

// File: rtl/dpm_ccflags_if.sv
// Bundle between the ALU/microcode side and the condition-code register.
interface dpm_ccflags_if;
  logic [2:0]  ccctl_h;
  logic [1:0]  dsize_h;
  logic        double_enable_h;
  logic        alu_c31_l;
  logic        alu_c15_l;
  logic        alu_c7_l;
  logic        alu_v31_h;
  logic        alu_v15_h;
  logic        alu_v7_h;
  logic [3:0]  wmuxz_h;
  logic [31:0] wbus_h;
  logic [3:0]  psl_cc_h;
  logic        pslc_h;
  logic [3:0]  ucc_h;
  logic        dbl_pend_h;

  modport master (
    output ccctl_h, dsize_h, double_enable_h,
    output alu_c31_l, alu_c15_l, alu_c7_l,
    output alu_v31_h, alu_v15_h, alu_v7_h,
    output wmuxz_h, wbus_h,
    input  psl_cc_h, pslc_h, ucc_h, dbl_pend_h
  );

  modport slave (
    input  ccctl_h, dsize_h, double_enable_h,
    input  alu_c31_l, alu_c15_l, alu_c7_l,
    input  alu_v31_h, alu_v15_h, alu_v7_h,
    input  wmuxz_h, wbus_h,
    output psl_cc_h, pslc_h, ucc_h, dbl_pend_h
  );
endinterface

// File: rtl/dpm_ccsel.sv
// Combinational size select: picks N, Z, V, C for the current data size.
module dpm_ccsel
  import dpm_pkg::*;
(
  input  logic [1:0] dsize,
  input  logic       sign31,
  input  logic       sign15,
  input  logic       sign7,
  input  logic [3:0] wmuxz,
  input  logic       c31_l,
  input  logic       c15_l,
  input  logic       c7_l,
  input  logic       v31,
  input  logic       v15,
  input  logic       v7,
  output cc_t        cur
);

  // Byte and word look at the low lanes only; long and quad use all 32 bits.
  always_comb begin
    cur = '0;
    case (dsize)
      DSIZE_BYTE: cur = '{n: sign7,  z: wmuxz[0],    v: v7,  c: ~c7_l};
      DSIZE_WORD: cur = '{n: sign15, z: &wmuxz[1:0], v: v15, c: ~c15_l};
      default:    cur = '{n: sign31, z: &wmuxz,      v: v31, c: ~c31_l};
    endcase
  end

endmodule

// File: rtl/dpm_ccflags.sv
// Condition-code and micro-flag register downstream of the ALU. Holds the
// PSL N/Z/V/C, the micro-branch flags, and the low-half zero flag of a
// double-cycle quad operation. All outputs come straight from registers.
module dpm_ccflags
  import dpm_pkg::*;
#(
  parameter logic [3:0] PSL_CC_RESET = 4'b0000
) (
  input logic           qd_clk_l,
  input logic           reset_h,
  dpm_ccflags_if.slave  bus
);

  cc_t    cur;
  cc_t    cur_eff;
  cc_t    psl_cc, psl_cc_nxt;
  cc_t    ucc, ucc_nxt;
  logic   zlo, zlo_nxt;
  state_t state, state_nxt;
  logic   start_dbl;
  logic   do_apply;

  dpm_ccsel u_ccsel (
    .dsize  (bus.dsize_h),
    .sign31 (bus.wbus_h[31]),
    .sign15 (bus.wbus_h[15]),
    .sign7  (bus.wbus_h[7]),
    .wmuxz  (bus.wmuxz_h),
    .c31_l  (bus.alu_c31_l),
    .c15_l  (bus.alu_c15_l),
    .c7_l   (bus.alu_c7_l),
    .v31    (bus.alu_v31_h),
    .v15    (bus.alu_v15_h),
    .v7     (bus.alu_v7_h),
    .cur    (cur)
  );

  assign start_dbl = bus.double_enable_h && (bus.dsize_h == DSIZE_QUAD) &&
                     is_flag_load(bus.ccctl_h);

  // In the high half of a quad the result is zero only if both halves were.
  always_comb begin
    cur_eff = cur;
    if (state == ST_DBL_HI) cur_eff.z = zlo & cur.z;
  end

  // Next-state and flag-update decode for the CC control field.
  always_comb begin
    state_nxt  = state;
    zlo_nxt    = zlo;
    psl_cc_nxt = psl_cc;
    ucc_nxt    = ucc;
    do_apply   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_dbl) begin
          state_nxt = ST_DBL_HI;
          zlo_nxt   = cur.z;
        end else begin
          do_apply = 1'b1;
        end
      end
      ST_DBL_HI: begin
        if (start_dbl) begin
          zlo_nxt = cur.z;
        end else if (bus.ccctl_h inside {CC_UCC, CC_ALL, CC_MOVE, CC_WLOAD, CC_CLRVC}) begin
          do_apply  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (do_apply) begin
      case (bus.ccctl_h)
        CC_UCC: ucc_nxt = cur_eff;
        CC_ALL: begin
          ucc_nxt    = cur_eff;
          psl_cc_nxt = cur_eff;
        end
        CC_MOVE: begin
          ucc_nxt      = cur_eff;
          psl_cc_nxt.n = cur_eff.n;
          psl_cc_nxt.z = cur_eff.z;
          psl_cc_nxt.v = 1'b0;
        end
        CC_WLOAD: psl_cc_nxt = bus.wbus_h[3:0];
        CC_CLRVC: begin
          psl_cc_nxt.v = 1'b0;
          psl_cc_nxt.c = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Flag and state registers, cleared asynchronously even mid-operation.
  always_ff @(posedge qd_clk_l or posedge reset_h) begin
    if (reset_h) begin
      state  <= ST_IDLE;
      zlo    <= 1'b0;
      psl_cc <= PSL_CC_RESET;
      ucc    <= '0;
    end else begin
      state  <= state_nxt;
      zlo    <= zlo_nxt;
      psl_cc <= psl_cc_nxt;
      ucc    <= ucc_nxt;
    end
  end

  assign bus.psl_cc_h   = psl_cc;
  assign bus.pslc_h     = psl_cc.c;
  assign bus.ucc_h      = ucc;
  assign bus.dbl_pend_h = (state == ST_DBL_HI);

endmodule

// File: doc/dpm_ccflags.md
# dpm_ccflags

Condition-code and micro-flag register for the DPM data path. It sits directly downstream of `aludp`. Each cycle it samples the ALU carry/overflow outputs, the per-byte zero flags (`wmuxz_h`) and the write-bus sign bits. It selects the result by data size and loads them into the micro-branch flags (UCC) and the PSL condition codes (N Z V C). It also accumulates the zero flag across the two halves of a double-cycle (quad) operation, and returns `pslc_h` to the ALK for carry-in.

## Interface

Parameters:
- `PSL_CC_RESET`, 4'b0000, reset value of {N,Z,V,C}.

Ports:
- `qd_clk_l` in 1: clock. All state updates on its rising edge. Single clock domain.
- `reset_h` in 1: reset, asynchronous, active-high.
- `ccctl_h` in 3: microcode CC control. Encodings are listed under Operation.
- `dsize_h` in 2: data size. 00 byte, 01 word, 10 long, 11 quad.
- `double_enable_h` in 1: high while the current ALU cycle is the low half of a double-cycle op.
- `alu_c31_l`, `alu_c15_l`, `alu_c7_l` in 1 each: active-low carries.
- `alu_v31_h`, `alu_v15_h`, `alu_v7_h` in 1 each: overflows.
- `wmuxz_h` in 4: per-byte zero flags, bit i = byte i zero.
- `wbus_h` in 32: write bus; supplies sign bits and CC load data.
- `psl_cc_h` out 4: PSL {N,Z,V,C}.
- `pslc_h` out 1: equals `psl_cc_h[0]`.
- `ucc_h` out 4: micro-flags {N,Z,V,C}.
- `dbl_pend_h` out 1: high while waiting for the high half of a double-cycle op.

## Operation

Size-selected flags (combinational, "cur"):
- Byte: N = `wbus_h[7]`; Z = `wmuxz_h[0]`; V = `alu_v7_h`; C = ~`alu_c7_l`.
- Word: N = `wbus_h[15]`; Z = &`wmuxz_h[1:0]`; V = `alu_v15_h`; C = ~`alu_c15_l`.
- Long / quad: N = `wbus_h[31]`; Z = &`wmuxz_h`; V = `alu_v31_h`; C = ~`alu_c31_l`.

`ccctl_h` encodings:
- 000 HOLD: nothing changes.
- 001 UCC: ucc ← cur.
- 010 ALL: ucc ← cur; psl_cc ← cur.
- 011 MOVE: ucc ← cur; psl N,Z ← cur; V ← 0; C unchanged.
- 100 WLOAD: psl_cc ← `wbus_h[3:0]`; ucc unchanged.
- 101 CLRVC: psl V ← 0, C ← 0; N,Z unchanged.
- 110, 111: treated as HOLD.

State machine, states IDLE and DBL_HI:
- IDLE → DBL_HI when `double_enable_h`=1, `dsize_h`=11 and `ccctl_h` ∈ {001,010,011}.
  - In that cycle zlo ← cur Z.
  - ucc and psl_cc do not change.
- DBL_HI, non-HOLD `ccctl_h`, `double_enable_h`=0: apply the encoding with Z replaced by zlo & cur Z, then go to IDLE.
  - For WLOAD or CLRVC, the encoding applies unchanged and the state goes to IDLE.
- DBL_HI, `double_enable_h`=1 (restart): zlo ← cur Z, stay in DBL_HI, no flag update.
- DBL_HI, HOLD: stay in DBL_HI; zlo holds.
- `double_enable_h`=1 with `dsize_h`≠11: ignored; the ordinary single-cycle rules apply.

Reset (asynchronous, also mid-operation):
- psl_cc = `PSL_CC_RESET`, ucc = 0000, zlo = 0, state IDLE.
- Therefore `dbl_pend_h` = 0 and `pslc_h` = `PSL_CC_RESET[0]`.

## Timing

- Inputs are sampled at a `qd_clk_l` rising edge. Updated flags are visible right after that edge, for use by the next microinstruction (latency 1).
- All outputs come straight from registers. `pslc_h` therefore has no combinational path from the ALU inputs, so there is no loop through the ALK.
- `dbl_pend_h` asserts the cycle after the low half and deasserts the cycle after the completing high half.

## Structure

Shared package `dpm_pkg` holds:
- `ccctl` encodings as localparams (CC_HOLD, CC_UCC, CC_ALL, CC_MOVE, CC_WLOAD, CC_CLRVC);
- data-size constants (DSIZE_BYTE/WORD/LONG/QUAD);
- the state enum (ST_IDLE, ST_DBL_HI).

One sub-module, `dpm_ccsel`: a purely combinational size-select producing cur {N,Z,V,C}. All registers stay in the top module.

## Test plan

- Reset asserted mid-DBL_HI → all outputs return immediately to reset values (`psl_cc_h`=PSL_CC_RESET, `ucc_h`=0, `dbl_pend_h`=0); no clock edge required.
- Byte ALL: `dsize_h`=00, `wbus_h`=0x00000080, `wmuxz_h`=4'b1110, `alu_c7_l`=0, `alu_v7_h`=1 → next cycle `psl_cc_h`=1011, `ucc_h`=1011, `pslc_h`=1.
- Word MOVE with prior psl_cc=0111: `dsize_h`=01, `wmuxz_h`=4'b0011, `wbus_h[15]`=0 → `psl_cc_h`=0101 (Z=1, V cleared, C kept).
- Quad ALL: low half with `double_enable_h`=1 and Z=1, then high half with `wmuxz_h`=4'b1111 → Z=1. Repeat with low-half `wmuxz_h`=4'b1011 → Z=0. Check `dbl_pend_h` is high for exactly one cycle, and psl_cc is unchanged after the low half.
- WLOAD: `ccctl_h`=100, `wbus_h`=0x0000000A → `psl_cc_h`=1010 and `ucc_h` unchanged. Then CLRVC → `psl_cc_h`=1000.
- DBL_HI restart: two consecutive low halves (`wmuxz_h`=0000, then 1111), then a high half with Z=1 → final Z=1, because zlo is overwritten by the second low half.
